// File: rtl/conv_engine.sv
// conv_engine: captures an N x N activation matrix and a K x K kernel, computes the
// valid-mode 2-D convolution on one time-multiplexed MAC, then streams the M x M
// results out over a valid/ready handshake.
module conv_engine #(
   parameter int unsigned DW  = 8,
   parameter int unsigned N   = 4,
   parameter int unsigned K   = 3,
   parameter bit          SAT = 1'b1,
   localparam int unsigned M  = N - K + 1,
   localparam int unsigned IW = (M * M > 1) ? $clog2(M * M) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [N*N*DW-1:0] a_flat,
   input  logic [K*K*DW-1:0] b_flat,
   output logic [DW-1:0]     result_o,
   output logic [IW-1:0]     result_idx_o,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [2:0]        state_o
);

   localparam int unsigned AW    = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned MW    = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned PW    = 2 * DW;
   localparam int unsigned ACC_W = 2 * DW + $clog2(K * K);

   localparam logic [IW-1:0] LastIdx = IW'(M * M - 1);
   localparam logic [MW-1:0] LastM   = MW'(M - 1);
   localparam logic [KW-1:0] LastK   = KW'(K - 1);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StCapture = 3'd1,
      StCompute = 3'd2,
      StOutput  = 3'd3,
      StDone    = 3'd4
   } state_e;

   state_e state_q, state_d;

   logic [DW-1:0]    a_mem [N][N];
   logic [DW-1:0]    b_mem [K][K];
   logic [DW-1:0]    rbuf  [M*M];

   logic [MW-1:0]    i_q, j_q;
   logic [KW-1:0]    u_q, v_q;
   logic             wb_q;
   logic [IW-1:0]    w_q, o_q;
   logic [ACC_W-1:0] acc_q;

   logic [AW-1:0]    row, col;
   logic [DW-1:0]    a_el, b_el, fmt;
   logic [PW-1:0]    prod;
   logic             capture, writeback;

   assign capture   = (state_q == StCapture);
   assign writeback = (state_q == StCompute) && wb_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state decode; run only matters in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (run) state_d = StCapture;
         StCapture: state_d = StCompute;
         StCompute: if (wb_q && (w_q == LastIdx)) state_d = StOutput;
         StOutput:  if (result_ready_i && (o_q == LastIdx)) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // MAC operand fetch, product and result formatting (saturate or wrap).
   always_comb begin
      row  = AW'(i_q) + AW'(u_q);
      col  = AW'(j_q) + AW'(v_q);
      a_el = a_mem[row][col];
      b_el = b_mem[u_q][v_q];
      prod = PW'(a_el) * PW'(b_el);
      if (SAT && (acc_q > ACC_W'({DW{1'b1}}))) fmt = '1;
      else                                      fmt = acc_q[DW-1:0];
   end

   // Per-element operand capture registers, loaded only in CAPTURE.
   for (genvar r = 0; r < N; r++) begin : g_a_row
      for (genvar c = 0; c < N; c++) begin : g_a_col
         // Activation element (r,c).
         always_ff @(posedge clk or posedge reset) begin
            if (reset)        a_mem[r][c] <= '0;
            else if (capture) a_mem[r][c] <= a_flat[(r*N+c)*DW +: DW];
         end
      end
   end

   for (genvar r = 0; r < K; r++) begin : g_b_row
      for (genvar c = 0; c < K; c++) begin : g_b_col
         // Kernel element (r,c).
         always_ff @(posedge clk or posedge reset) begin
            if (reset)        b_mem[r][c] <= '0;
            else if (capture) b_mem[r][c] <= b_flat[(r*K+c)*DW +: DW];
         end
      end
   end

   // Result buffer; survives DONE/IDLE, only overwritten by the next job's writebacks.
   for (genvar g = 0; g < M * M; g++) begin : g_rbuf
      // Result slot g, written on its writeback cycle.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)                                rbuf[g] <= '0;
         else if (writeback && (w_q == IW'(g)))    rbuf[g] <= fmt;
      end
   end

   // Accumulator, loop counters and output index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         i_q   <= '0;
         j_q   <= '0;
         u_q   <= '0;
         v_q   <= '0;
         wb_q  <= 1'b0;
         w_q   <= '0;
         o_q   <= '0;
      end else begin
         case (state_q)
            StCapture: begin
               acc_q <= '0;
               i_q   <= '0;
               j_q   <= '0;
               u_q   <= '0;
               v_q   <= '0;
               wb_q  <= 1'b0;
               w_q   <= '0;
               o_q   <= '0;
            end
            StCompute: begin
               if (!wb_q) begin
                  acc_q <= acc_q + ACC_W'(prod);
                  if (v_q == LastK) begin
                     v_q <= '0;
                     if (u_q == LastK) begin
                        u_q  <= '0;
                        wb_q <= 1'b1;
                     end else begin
                        u_q <= u_q + 1'b1;
                     end
                  end else begin
                     v_q <= v_q + 1'b1;
                  end
               end else begin
                  // Writeback cycle: rbuf is written by g_rbuf, advance to next output.
                  acc_q <= '0;
                  wb_q  <= 1'b0;
                  if (w_q != LastIdx) w_q <= w_q + 1'b1;
                  if (j_q == LastM) begin
                     j_q <= '0;
                     i_q <= i_q + 1'b1;
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
               end
            end
            StOutput: begin
               if (result_ready_i && (o_q != LastIdx)) o_q <= o_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from registered state and rbuf only.
   always_comb begin
      result_valid_o = (state_q == StOutput);
      result_o       = result_valid_o ? rbuf[o_q] : '0;
      result_idx_o   = result_valid_o ? o_q : '0;
      busy_o         = (state_q != StIdle);
      done_o         = (state_q == StDone);
      state_o        = state_q;
   end

endmodule
